// File: rtl/eb_fifo_n.sv
// N-entry valid/ready elastic FIFO with occupancy output and synchronous flush.
// Optional zero-latency empty bypass when EB_FIFO_N_BYPASS_EN is defined.
module eb_fifo_n #(
    parameter int DWIDTH = 32,
    parameter int DEPTH  = 4,
    localparam int CWIDTH = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic [DWIDTH-1:0] t_data,
    input  logic              t_valid,
    output logic              t_ready,
    output logic [DWIDTH-1:0] i_data,
    output logic              i_valid,
    input  logic              i_ready,
    output logic [CWIDTH-1:0] count
);
    localparam int PWIDTH = $clog2(DEPTH);
    localparam logic [PWIDTH-1:0] LAST = PWIDTH'(DEPTH - 1);
    localparam logic [CWIDTH-1:0] FULL = CWIDTH'(DEPTH);

    logic [DWIDTH-1:0] mem [DEPTH];
    logic [PWIDTH-1:0] wr_ptr_q;
    logic [PWIDTH-1:0] rd_ptr_q;
    logic [CWIDTH-1:0] count_q;
    logic [CWIDTH-1:0] count_d;
    logic              t_ready_q;
    logic              not_empty;
    logic              push_mem;
    logic              pop_mem;

    assign not_empty = (count_q != '0);
    assign pop_mem   = not_empty & i_ready;
    assign t_ready   = t_ready_q;
    assign count     = count_q;

`ifdef EB_FIFO_N_BYPASS_EN
    logic bypass;
    // A beat offered to an empty buffer is shown downstream at once; it is
    // only written into storage if the consumer does not take it this cycle.
    assign bypass   = ~not_empty & t_valid & t_ready_q & ~flush & ~rst;
    assign i_valid  = not_empty | bypass;
    assign i_data   = not_empty ? mem[rd_ptr_q] : t_data;
    assign push_mem = t_valid & t_ready_q & ~(bypass & i_ready);
`else
    assign i_valid  = not_empty;
    assign i_data   = mem[rd_ptr_q];
    assign push_mem = t_valid & t_ready_q;
`endif

    always_comb begin
        count_d = count_q;
        if (push_mem && !pop_mem) begin
            count_d = count_q + CWIDTH'(1);
        end else if (pop_mem && !push_mem) begin
            count_d = count_q - CWIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q   <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            t_ready_q <= 1'b0;
        end else if (flush) begin
            count_q   <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            t_ready_q <= 1'b1;
        end else begin
            count_q   <= count_d;
            t_ready_q <= (count_d < FULL);
            // Explicit wrap keeps non-power-of-two depths correct.
            if (push_mem) begin
                wr_ptr_q <= (wr_ptr_q == LAST) ? '0 : wr_ptr_q + PWIDTH'(1);
            end
            if (pop_mem) begin
                rd_ptr_q <= (rd_ptr_q == LAST) ? '0 : rd_ptr_q + PWIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push_mem && !flush && !rst) begin
            mem[wr_ptr_q] <= t_data;
        end
    end

endmodule

// File: tb/tb_eb_fifo_n.sv
// Self-checking bench for eb_fifo_n: DEPTH=4 directed tests plus a DEPTH=3
// randomised wrap test, both checked against a queue scoreboard.
module tb_eb_fifo_n;

    logic       clk = 1'b0;
    logic       rst;
    logic       flush;
    logic [7:0] t_data;
    logic       t_valid;
    logic       t_ready;
    logic [7:0] i_data;
    logic       i_valid;
    logic       i_ready;
    logic [2:0] count;

    logic       flush3;
    logic [7:0] t_data3;
    logic       t_valid3;
    logic       t_ready3;
    logic [7:0] i_data3;
    logic       i_valid3;
    logic       i_ready3;
    logic [1:0] count3;

    int checks   = 0;
    int failures = 0;
    int pops3    = 0;
    bit mon_en   = 1'b0;
    bit mon3_en  = 1'b0;
    logic [7:0] q[$];
    logic [7:0] q3[$];

    always #5 clk = ~clk;

    eb_fifo_n #(.DWIDTH(8), .DEPTH(4)) u_dut (
        .clk    (clk),
        .rst    (rst),
        .flush  (flush),
        .t_data (t_data),
        .t_valid(t_valid),
        .t_ready(t_ready),
        .i_data (i_data),
        .i_valid(i_valid),
        .i_ready(i_ready),
        .count  (count)
    );

    eb_fifo_n #(.DWIDTH(8), .DEPTH(3)) u_dut3 (
        .clk    (clk),
        .rst    (rst),
        .flush  (flush3),
        .t_data (t_data3),
        .t_valid(t_valid3),
        .t_ready(t_ready3),
        .i_data (i_data3),
        .i_valid(i_valid3),
        .i_ready(i_ready3),
        .count  (count3)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard for the DEPTH=4 instance.
    always @(negedge clk) begin
        if (mon_en) begin
            chk("count_model", 32'(count), 32'(q.size()));
            if (flush) begin
                if (i_valid && i_ready && q.size() != 0) chk("flush_pop", 32'(i_data), 32'(q[0]));
                q.delete();
            end else begin
                if (t_valid && t_ready) q.push_back(t_data);
                if (i_valid && i_ready) begin
                    if (q.size() == 0) chk("pop_underrun", 32'(q.size()), 32'd1);
                    else chk("data_order", 32'(i_data), 32'(q.pop_front()));
                end
            end
        end
    end

    // Scoreboard for the DEPTH=3 instance.
    always @(negedge clk) begin
        if (mon3_en) begin
            chk("d3_count_model", 32'(count3), 32'(q3.size()));
            chk("d3_count_max", 32'(count3 <= 2'd3), 32'd1);
            if (t_valid3 && t_ready3) q3.push_back(t_data3);
            if (i_valid3 && i_ready3) begin
                pops3++;
                if (q3.size() == 0) chk("d3_pop_underrun", 32'(q3.size()), 32'd1);
                else chk("d3_data_order", 32'(i_data3), 32'(q3.pop_front()));
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int idx;
        rst = 1'b1; flush = 1'b0; t_valid = 1'b1; t_data = 8'h11; i_ready = 1'b0;
        flush3 = 1'b0; t_valid3 = 1'b0; t_data3 = 8'h00; i_ready3 = 1'b0;

        // 1. Reset held three cycles with t_valid high.
        tick(); tick(); tick();
        @(negedge clk);
        chk("rst_t_ready", 32'(t_ready), 32'd0);
        chk("rst_i_valid", 32'(i_valid), 32'd0);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_count3", 32'(count3), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0; t_valid = 1'b0;
        tick();
        mon_en = 1'b1; mon3_en = 1'b1;
        @(negedge clk);
        chk("post_rst_t_ready", 32'(t_ready), 32'd1);
        chk("post_rst_t_ready3", 32'(t_ready3), 32'd1);

        // 2. Streaming with i_ready held high.
        @(posedge clk); #1;
        i_ready = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            t_valid = 1'b1; t_data = 8'(i);
            @(negedge clk);
            chk("stream_t_ready", 32'(t_ready), 32'd1);
`ifdef EB_FIFO_N_BYPASS_EN
            chk("stream_count", 32'(count), 32'd0);
`else
            if (i > 1) begin
                chk("stream_count", 32'(count), 32'd1);
                chk("stream_data", 32'(i_data), 32'(i - 1));
            end
`endif
            tick();
        end
        t_valid = 1'b0;
        tick(); tick();
        @(negedge clk);
        chk("stream_drained_cnt", 32'(count), 32'd0);
        chk("stream_drained_q", 32'(q.size()), 32'd0);

        // 3. Fill against backpressure, then drain.
        @(posedge clk); #1;
        i_ready = 1'b0;
        for (int k = 0; k < 6; k++) begin
            t_valid = 1'b1; t_data = 8'hA0 + 8'(k);
            @(negedge clk);
            chk("fill_t_ready", 32'(t_ready), (k < 4) ? 32'd1 : 32'd0);
            tick();
        end
        @(negedge clk);
        chk("full_count", 32'(count), 32'd4);
        chk("full_t_ready", 32'(t_ready), 32'd0);
        chk("full_head", 32'(i_data), 32'hA0);
        @(posedge clk); #1;
        idx = 4;
        for (int c = 0; c < 20 && idx < 6; c++) begin
            t_valid = 1'b1; t_data = 8'hA0 + 8'(idx); i_ready = 1'b1;
            @(negedge clk);
            if (t_ready) idx++;
            tick();
        end
        chk("fill_tail_accepted", 32'(idx), 32'd6);
        t_valid = 1'b0;
        for (int c = 0; c < 10 && count != 0; c++) tick();
        @(negedge clk);
        chk("fill_drained_cnt", 32'(count), 32'd0);
        chk("fill_drained_q", 32'(q.size()), 32'd0);

        // 5. Flush with three entries held and a push offered.
        @(posedge clk); #1;
        i_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            t_valid = 1'b1; t_data = 8'hB0 + 8'(k);
            tick();
        end
        t_valid = 1'b0;
        @(negedge clk);
        chk("preflush_count", 32'(count), 32'd3);
        @(posedge clk); #1;
        flush = 1'b1; t_valid = 1'b1; t_data = 8'hEE;
        tick();
        flush = 1'b0; t_valid = 1'b0;
        @(negedge clk);
        chk("flush_count", 32'(count), 32'd0);
        chk("flush_i_valid", 32'(i_valid), 32'd0);
        chk("flush_t_ready", 32'(t_ready), 32'd1);
        @(posedge clk); #1;
        t_valid = 1'b1; t_data = 8'h5A;
        tick();
        t_valid = 1'b0;
        @(negedge clk);
        chk("postflush_valid", 32'(i_valid), 32'd1);
        chk("postflush_data", 32'(i_data), 32'h5A);
        @(posedge clk); #1;
        i_ready = 1'b1;
        tick();
        @(negedge clk);
        chk("postflush_drained", 32'(count), 32'd0);

        // 6. Single beat into an empty buffer.
        @(posedge clk); #1;
        t_valid = 1'b1; t_data = 8'h77; i_ready = 1'b1;
        @(negedge clk);
`ifdef EB_FIFO_N_BYPASS_EN
        chk("byp_valid", 32'(i_valid), 32'd1);
        chk("byp_data", 32'(i_data), 32'h77);
        chk("byp_count", 32'(count), 32'd0);
        tick();
        t_valid = 1'b0;
        @(negedge clk);
        chk("byp_count_after", 32'(count), 32'd0);
`else
        chk("lat_valid0", 32'(i_valid), 32'd0);
        tick();
        t_valid = 1'b0;
        @(negedge clk);
        chk("lat_valid1", 32'(i_valid), 32'd1);
        chk("lat_data1", 32'(i_data), 32'h77);
        chk("lat_count1", 32'(count), 32'd1);
        tick();
        @(negedge clk);
        chk("lat_count_after", 32'(count), 32'd0);
`endif

        // 4. DEPTH=3 random traffic, 1000 delivered beats.
        @(posedge clk); #1;
        for (int c = 0; c < 8000 && pops3 < 1000; c++) begin
            t_valid3 = 1'($urandom_range(0, 1));
            i_ready3 = 1'($urandom_range(0, 1));
            t_data3  = 8'($urandom_range(0, 255));
            tick();
        end
        chk("d3_beats", 32'(pops3 >= 1000), 32'd1);
        t_valid3 = 1'b0; i_ready3 = 1'b1;
        for (int c = 0; c < 10 && count3 != 0; c++) tick();
        @(negedge clk);
        chk("d3_drained_cnt", 32'(count3), 32'd0);
        chk("d3_drained_q", 32'(q3.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/eb_fifo_n.md
Name: eb_fifo_n

Overview:
- Parametrised successor to the fixed 1.5-entry elastic buffer: an N-entry valid/ready elastic FIFO.
- Sits between a producer on the t_ interface and a consumer on the i_ interface.
- Full throughput; no combinational path from i_ready to t_ready.
- Adds an occupancy output and a synchronous flush. Used wherever pipeline stages need more slack than 1.5 entries.

Parameters:
- DWIDTH, 32, payload width in bits (>=1).
- DEPTH, 4, number of storage entries (>=2; need not be a power of two).
- CWIDTH, $clog2(DEPTH+1), width of count; derived, not to be overridden.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  reset, synchronous, active-high.
- flush  input  1  synchronous clear of all stored entries.
- t_data  input  DWIDTH  upstream payload.
- t_valid  input  1  upstream beat valid.
- t_ready  output  1  buffer can accept a beat.
- i_data  output  DWIDTH  downstream payload.
- i_valid  output  1  downstream beat valid.
- i_ready  input  1  downstream accepts beat.
- count  output  CWIDTH  entries currently held, 0..DEPTH.

Behaviour:
- Clocking and reset:
  - One clock domain.
  - Reset is synchronous and active-high: sampled on the rising edge of clk.
- Handshake definitions:
  - push = t_valid & t_ready.
  - pop = i_valid & i_ready.
  - Standard valid/ready rules apply. Once i_valid is high, i_data holds stable and i_valid stays high until pop.
- Storage:
  - Circular register array of DEPTH entries, addressed by wr_ptr and rd_ptr.
  - Each pointer wraps from DEPTH-1 to 0 explicitly, so non-power-of-two DEPTH is supported.
- State: count register.
  - push only: count+1.
  - pop only: count-1.
  - push and pop together: count unchanged; both pointers advance.
- Outputs (no combinational input->output path in base build):
  - t_ready is a register equal to (next count < DEPTH), so it depends on state only.
  - i_valid = (count != 0).
  - i_data = mem[rd_ptr].
- Latency: a beat pushed in cycle N is presented on i_valid/i_data in cycle N+1.
- Throughput: one beat per cycle sustained when i_ready is held high.
- Full (count == DEPTH):
  - t_ready = 0; upstream stalls.
  - A pop in that cycle raises t_ready in the next cycle. Full-cycle pop and push cannot coincide.
- Empty (count == 0): i_valid = 0; i_ready is ignored.
- Flush:
  - Flush=1 sets count=0, wr_ptr=0, rd_ptr=0 at the next edge.
  - A push or pop in the flush cycle is discarded and counts as consumed/dropped.
  - t_ready = 1 the cycle after.
- Reset:
  - Reset overrides flush. At the edge with rst=1: count=0, pointers=0, t_ready=0, i_valid=0.
  - t_ready rises the first cycle after rst deasserts.
  - Storage registers are not reset, so i_data is don't-care while i_valid=0.
  - Reset mid-stream drops all held data.
- count width: CWIDTH bits; never exceeds DEPTH, never underflows.

Optional Feature:
- Macro: EB_FIFO_N_BYPASS_EN.
- Defined:
  - When count == 0, i_valid = t_valid and i_data = t_data combinationally.
  - If i_ready is also high, the beat passes with zero latency and is not stored: count and pointers are unchanged.
  - If i_ready is low, the beat is stored normally.
  - Flush or rst high suppresses bypass: i_valid = 0.
- Undefined: no bypass. Minimum latency is 1 cycle, and all outputs are register-derived.

Test Plan (DWIDTH=8, DEPTH=4 unless noted):
1. Reset: hold rst=1 for 3 cycles with t_valid=1 -> t_ready=0, i_valid=0, count=0; first cycle after release t_ready=1.
2. Streaming: push 0x01..0x10 with i_ready=1 continuously -> i_data 0x01..0x10 in order, one per cycle, 1-cycle latency, count steady at 1, no stall.
3. Fill/backpressure: i_ready=0, push 0xA0..0xA5 -> 0xA0..0xA3 accepted, count=4, t_ready=0. Then raise i_ready -> 0xA0..0xA5 delivered in order with no loss or duplicate.
4. Wrap with DEPTH=3: random t_valid/i_ready at 50% for 1000 beats -> scoreboard order exact, count matches model every cycle, count never >3.
5. Flush: with count=3, assert flush alongside t_valid=1 -> next cycle count=0, i_valid=0, t_ready=1; a subsequent push of 0x5A emerges as the next i_data.
6. With EB_FIFO_N_BYPASS_EN, empty buffer, t_valid=1 t_data=0x77 i_ready=1 -> i_valid=1 and i_data=0x77 in the same cycle, count stays 0. Without the macro -> appears the next cycle, count=1 momentarily.
